// File: rtl/progmem_loader.sv
// Boot-time program memory loader: parses a length/word/checksum byte frame,
// writes words into progmem from address 0 and holds the CPU until a clean load.
module progmem_loader #(
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_din,
  output logic        o_mem_write_en,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_error
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned EW = 2;

  localparam logic [EW-1:0] ERR_NONE = 2'b00;
  localparam logic [EW-1:0] ERR_LEN  = 2'b01;
  localparam logic [EW-1:0] ERR_CSUM = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic            r_rx_ready;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_din;
  logic            r_mem_write_en;
  logic            r_cpu_hold;
  logic            r_busy;
  logic            r_done;
  logic [EW-1:0]   r_error;
  logic [AW-1:0]   r_len;
  logic [AW-1:0]   r_idx;
  logic [BW-1:0]   r_sum;
  logic [BW-1:0]   r_word_hi;

  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_start_ok;
  logic [AW-1:0]   w_len_full;
  logic [AW-1:0]   w_idx_inc;
  logic [BW-1:0]   w_sum_nxt;
  logic [EW-1:0]   w_error_nxt;
  logic            w_rx_ready_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_cpu_hold_nxt;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = i_rx_valid && r_rx_ready;
    w_start_ok     = 1'b0;
    w_len_full     = {r_len[AW-1:BW], i_rx_data};
    w_idx_inc      = r_idx + AW'(1);
    w_sum_nxt      = r_sum;
    w_error_nxt    = r_error;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_LEN_HI;
          w_sum_nxt   = '0;
          w_error_nxt = ERR_NONE;
        end
      end
      S_LEN_HI: begin
        if (w_accept) begin
          w_state_nxt = S_LEN_LO;
          w_sum_nxt   = r_sum + i_rx_data;
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          w_sum_nxt = r_sum + i_rx_data;
          if ((w_len_full == '0) || (w_len_full > AW'(MAX_WORDS))) begin
            w_state_nxt = S_ERR;
            w_error_nxt = ERR_LEN;
          end else begin
            w_state_nxt = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (w_accept) begin
          w_state_nxt = S_DATA_LO;
          w_sum_nxt   = r_sum + i_rx_data;
        end
      end
      S_DATA_LO: begin
        if (w_accept) begin
          w_state_nxt = S_WRITE;
          w_sum_nxt   = r_sum + i_rx_data;
        end
      end
      S_WRITE: begin
        w_state_nxt = (w_idx_inc == r_len) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        // Checksum byte is compared, never folded into the sum
        if (w_accept) begin
          if (i_rx_data == r_sum) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ERR;
            w_error_nxt = ERR_CSUM;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_rx_ready_nxt = (w_state_nxt == S_LEN_HI)  || (w_state_nxt == S_LEN_LO) ||
                     (w_state_nxt == S_DATA_HI) || (w_state_nxt == S_DATA_LO) ||
                     (w_state_nxt == S_CSUM);
    w_busy_nxt     = !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) ||
                       (w_state_nxt == S_ERR));
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_cpu_hold_nxt = (w_state_nxt != S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_rx_ready     <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_din      <= '0;
      r_mem_write_en <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= ERR_NONE;
      r_len          <= '0;
      r_idx          <= '0;
      r_sum          <= '0;
      r_word_hi      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_rx_ready     <= w_rx_ready_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_cpu_hold     <= w_cpu_hold_nxt;
      r_error        <= w_error_nxt;
      r_sum          <= w_sum_nxt;
      r_mem_write_en <= (w_state_nxt == S_WRITE);

      if (w_start_ok) begin
        r_idx <= '0;
      end else if (r_state == S_WRITE) begin
        r_idx <= w_idx_inc;
      end

      if (w_accept && (r_state == S_LEN_HI)) begin
        r_len[AW-1:BW] <= i_rx_data;
      end
      if (w_accept && (r_state == S_LEN_LO)) begin
        r_len <= w_len_full;
      end
      if (w_accept && (r_state == S_DATA_HI)) begin
        r_word_hi <= i_rx_data;
      end
      // Address/data are presented together with the strobe in WRITE
      if (w_accept && (r_state == S_DATA_LO)) begin
        r_mem_addr <= r_idx;
        r_mem_din  <= {r_word_hi, i_rx_data};
      end
    end
  end

  assign o_rx_ready     = r_rx_ready;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_din      = r_mem_din;
  assign o_mem_write_en = r_mem_write_en;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule

// File: tb/tb_progmem_loader.sv
// Self-checking bench for progmem_loader: frames are built from word lists with
// an arithmetic checksum and the captured progmem writes are compared to them.
module tb_progmem_loader;

  localparam int unsigned MAX_WORDS = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_write_en;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [1:0]  error;

  int checks = 0;
  int failures = 0;

  logic [15:0] pm [0:1023];
  int wr_count;
  int wr_order_err;
  int wr_oob;
  int wr_ready_viol;
  int next_addr;
  int cur_n;

  logic [7:0]  frame [$];
  logic [15:0] words [$];

  progmem_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (rx_ready),
    .o_mem_addr     (mem_addr),
    .o_mem_din      (mem_din),
    .o_mem_write_en (mem_write_en),
    .o_cpu_hold     (cpu_hold),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error)
  );

  always #5 clk = ~clk;

  // Progmem stand-in: records every strobed write
  always @(posedge clk) begin
    if (mem_write_en) begin
      pm[mem_addr[9:0]] = mem_din;
      wr_count++;
      if (int'(mem_addr) != next_addr) wr_order_err++;
      if (int'(mem_addr) >= cur_n) wr_oob++;
      if (rx_ready) wr_ready_viol++;
      next_addr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log(input int n);
    wr_count = 0; wr_order_err = 0; wr_oob = 0; wr_ready_viol = 0;
    next_addr = 0; cur_n = n;
  endtask

  // Frame = length, words (only if the length is legal), 8-bit sum + delta
  task automatic make_frame(input logic [15:0] n, input logic [7:0] delta);
    int sum;
    frame.delete();
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    if (n == 0 || n > MAX_WORDS) return;
    for (int i = 0; i < int'(n); i++) begin
      frame.push_back(words[i][15:8]);
      frame.push_back(words[i][7:0]);
    end
    sum = 0;
    foreach (frame[i]) sum += int'(frame[i]);
    frame.push_back(8'((sum % 256) + int'(delta)));
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    rx_data = b;
    rx_valid = 1'b1;
    waited = 0;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("accept_timeout", 32'(waited), 32'(0));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gapmax);
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      send_byte(frame[i]);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'(1));
    check({tag, "_ready_after_start"}, 32'(rx_ready), 32'(1));
  endtask

  task automatic check_mem(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (pm[i] !== words[i]) bad++;
    check({tag, "_mem_words_bad"}, 32'(bad), 32'(0));
  endtask

  // Full load; expected outcome follows from the frame rules, not the DUT
  task automatic run_load(input string tag, input logic [15:0] n, input logic [7:0] delta,
                          input int gapmax);
    logic        len_bad;
    logic [1:0]  exp_err;
    int          exp_writes;
    len_bad    = (n == 0) || (n > MAX_WORDS);
    exp_err    = len_bad ? 2'b01 : ((delta != 0) ? 2'b10 : 2'b00);
    exp_writes = len_bad ? 0 : int'(n);
    clear_log(exp_writes);
    make_frame(n, delta);
    do_start(tag);
    send_range(0, frame.size() - 1, gapmax);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_done"}, 32'(done), 32'(exp_err == 2'b00));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err != 2'b00));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'(0));
    check({tag, "_writes"}, 32'(wr_count), 32'(exp_writes));
    check({tag, "_order"}, 32'(wr_order_err), 32'(0));
    check({tag, "_oob"}, 32'(wr_oob), 32'(0));
    check({tag, "_ready_in_write"}, 32'(wr_ready_viol), 32'(0));
    if (!len_bad) check_mem(tag, int'(n));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    clear_log(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_cpu_hold", 32'(cpu_hold), 32'(1));
    check("rst_rx_ready", 32'(rx_ready), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_din", 32'(mem_din), 32'(0));
    check("rst_write_en", 32'(mem_write_en), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_error", 32'(error), 32'(0));

    // Reference frame 00 02 12 34 AB CD C0
    words.delete(); words.push_back(16'h1234); words.push_back(16'hABCD);
    make_frame(16'd2, 8'd0);
    check("good_frame_csum", 32'(frame[6]), 32'h0000_00C0);
    run_load("good", 16'd2, 8'd0, 0);

    run_load("csum_err", 16'd2, 8'd1, 0);
    rand_words(7);
    run_load("recover", 16'd7, 8'd0, 3);

    run_load("len_zero", 16'd0, 8'd0, 0);
    run_load("len_513", 16'd513, 8'd0, 0);

    rand_words(9);
    run_load("backpressure", 16'd9, 8'd0, 5);
    rand_words(1);
    run_load("single", 16'd1, 8'd0, 2);
    rand_words(MAX_WORDS);
    run_load("max_len", 16'(MAX_WORDS), 8'd0, 0);

    // Reset after word 0 has been written
    words.delete(); words.push_back(16'h1234); words.push_back(16'h5678);
    words.push_back(16'h9ABC);
    clear_log(3);
    make_frame(16'd3, 8'd0);
    do_start("midrst");
    send_range(0, 3, 0);
    @(negedge clk);
    check("midrst_word0_written", 32'(wr_count), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_cpu_hold", 32'(cpu_hold), 32'(1));
    check("midrst_write_en", 32'(mem_write_en), 32'(0));
    rx_data = 8'h55; rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    check("midrst_rx_ready", 32'(rx_ready), 32'(0));
    check("midrst_no_more_writes", 32'(wr_count), 32'(1));
    check("midrst_mem0", 32'(pm[0]), 32'h0000_1234);

    // Spurious start while in DATA_LO
    rand_words(2);
    clear_log(2);
    make_frame(16'd2, 8'd0);
    do_start("spur");
    send_range(0, 2, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("spur_still_busy", 32'(busy), 32'(1));
    send_range(3, frame.size() - 1, 1);
    check("spur_done", 32'(done), 32'(1));
    check("spur_error", 32'(error), 32'(0));
    check("spur_writes", 32'(wr_count), 32'(2));
    check("spur_order", 32'(wr_order_err), 32'(0));
    check_mem("spur", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
